regfile_mp: RTL and testbench

//  Parametrised multi-read-port register file; successor to the single-issue pipeline regfile.

---
 rtl/regfile_mp.sv | 98 +++++++++
 tb/tb_regfile_mp.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file: posedge write with same-cycle bypass, hardwired x0,
// sticky trigger write, and a post-reset sweep that zeroes every entry.
module regfile_mp #(
   parameter int unsigned ADDRESS_WIDTH = 5,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned NUM_READ      = 2,
   parameter int unsigned TRIG_REG      = 5,
   parameter int unsigned TRIG_VALUE    = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_READ*ADDRESS_WIDTH-1:0] rd_addr,
   output logic [NUM_READ*DATA_WIDTH-1:0]    rd_data,
   input  logic                              we,
   input  logic [ADDRESS_WIDTH-1:0]          wa,
   input  logic [DATA_WIDTH-1:0]             wd,
   input  logic                              trigger,
   output logic                              busy,
   output logic [DATA_WIDTH-1:0]             a0,
   output logic [DATA_WIDTH-1:0]             ra
);

   localparam int unsigned Depth = 2 ** ADDRESS_WIDTH;
   localparam int unsigned IdxA0 = 10;
   localparam int unsigned IdxRa = 1;
   localparam logic [ADDRESS_WIDTH-1:0] TrigAddr = ADDRESS_WIDTH'(TRIG_REG);
   localparam logic [DATA_WIDTH-1:0]    TrigData = DATA_WIDTH'(TRIG_VALUE);

   typedef enum logic {StClear, StReady} state_e;

   state_e                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
   logic                     pend_q, pend_d;
   logic [DATA_WIDTH-1:0]    mem_q [Depth];
   logic                     ready, trig_eff, wr_en;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      pend_d  = pend_q;
      unique case (state_q)
         StClear: begin
            ptr_d = ptr_q + 1'b1;
            if (trigger) pend_d = 1'b1;
            if (ptr_q == '1) state_d = StReady;
         end
         StReady: pend_d = 1'b0;
         default: state_d = StClear;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StClear;
         ptr_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         pend_q  <= pend_d;
      end
   end

   assign busy     = rst || (state_q == StClear);
   assign ready    = !busy;
   // A trigger caught during the sweep is replayed on the first ready cycle.
   assign trig_eff = ready && (trigger || pend_q);
   assign wr_en    = ready && we && (wa != '0);

   always_ff @(posedge clk) begin
      if (!rst && state_q == StClear) begin
         mem_q[ptr_q] <= '0;
      end else begin
         if (wr_en && !(trig_eff && wa == TrigAddr)) mem_q[wa] <= wd;
         if (trig_eff && TrigAddr != '0) mem_q[TrigAddr] <= TrigData;
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < int'(NUM_READ); i++) begin
         if (ready && rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] != '0) begin
            if (trig_eff && rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] == TrigAddr) begin
               rd_data[i*DATA_WIDTH +: DATA_WIDTH] = TrigData;
            end else if (we && rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] == wa) begin
               rd_data[i*DATA_WIDTH +: DATA_WIDTH] = wd;
            end else begin
               rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
                  mem_q[rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]];
            end
         end
      end
   end

   assign a0 = busy ? '0 : mem_q[IdxA0];
   assign ra = busy ? '0 : mem_q[IdxRa];

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized self-checking bench for regfile_mp against a cycle-level behavioural model.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic        trigger;
   logic        busy;
   logic [31:0] a0;
   logic [31:0] ra;

   int checks = 0;
   int errors = 0;

   // Behavioural model: committed contents, remaining sweep cycles, pending trigger.
   logic [31:0] mdl [32];
   int          sweep_left = 32;
   bit          pend = 1'b0;

   regfile_mp dut (
      .clk     (clk),
      .rst     (rst),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .we      (we),
      .wa      (wa),
      .wd      (wd),
      .trigger (trigger),
      .busy    (busy),
      .a0      (a0),
      .ra      (ra)
   );

   always #5 clk = ~clk;

   function automatic bit m_busy();
      return rst || sweep_left > 0;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (m_busy()) return 32'd0;
      if (a == 5'd0) return 32'd0;
      if ((trigger || pend) && a == 5'd5) return 32'd1;
      if (we && a == wa) return wd;
      return mdl[a];
   endfunction

   function automatic logic [31:0] exp_tap(input int idx);
      if (m_busy()) return 32'd0;
      return mdl[idx];
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         sweep_left = 32;
         pend = 1'b0;
      end else if (sweep_left > 0) begin
         if (trigger) pend = 1'b1;
         sweep_left--;
         if (sweep_left == 0) for (int k = 0; k < 32; k++) mdl[k] = 32'd0;
      end else begin
         if (we && wa != 5'd0) mdl[wa] = wd;
         if (trigger || pend) mdl[5] = 32'd1;
         pend = 1'b0;
      end
      #1;
   endtask

   task automatic idle();
      we = 1'b0;
      wa = 5'd0;
      wd = 32'd0;
      trigger = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      idle();
      rst = 1'b1;
      rd_addr = {5'd3, 5'd7};
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (busy !== 1'b1 || rd_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b rd_data=%h, required busy=1 rd_data=0", busy,
                     rd_data);
         end
         tick();
      end
      rst = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         we = 1'($urandom_range(0, 1));
         wa = 5'($urandom);
         wd = $urandom;
         rd_addr = 10'($urandom);
         #1;
         checks++;
         if (rd_data !== 64'd0 || a0 !== 32'd0 || ra !== 32'd0) begin
            errors++;
            $display("FAIL sweep_reads: rd_data=%h a0=%h ra=%h, required all 0", rd_data, a0, ra);
         end
         n++;
         tick();
      end
      idle();
      checks++;
      if (n != 32) begin
         errors++;
         $display("FAIL sweep_length: busy cycles=%0d, required 32", n);
      end
      for (int a = 0; a < 32; a += 2) begin
         rd_addr = {5'(a + 1), 5'(a)};
         #1;
         checks++;
         if (rd_data !== {exp_rd(5'(a + 1)), exp_rd(5'(a))}) begin
            errors++;
            $display("FAIL post_sweep_zero: addr %0d/%0d got %h, required %h", a, a + 1,
                     rd_data, {exp_rd(5'(a + 1)), exp_rd(5'(a))});
         end
      end
   endtask

   task automatic test_bypass();
      we = 1'b1;
      wa = 5'd7;
      wd = 32'hDEADBEEF;
      rd_addr = {5'd3, 5'd7};
      #1;
      checks++;
      if (rd_data[31:0] !== 32'hDEADBEEF || rd_data[63:32] !== exp_rd(5'd3)) begin
         errors++;
         $display("FAIL bypass_same_cycle: got %h, required %h", rd_data,
                  {exp_rd(5'd3), 32'hDEADBEEF});
      end
      tick();
      idle();
      rd_addr = {5'd7, 5'd7};
      #1;
      checks++;
      if (rd_data !== {2{32'hDEADBEEF}}) begin
         errors++;
         $display("FAIL bypass_committed: got %h, required %h", rd_data, {2{32'hDEADBEEF}});
      end
   endtask

   task automatic test_x0();
      we = 1'b1;
      wa = 5'd0;
      wd = 32'h1234;
      rd_addr = {5'd0, 5'd0};
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (rd_data !== 64'd0) begin
            errors++;
            $display("FAIL x0_zero: cycle %0d got %h, required 0", c, rd_data);
         end
         tick();
         idle();
      end
   endtask

   task automatic test_trigger_priority();
      we = 1'b1;
      wa = 5'd5;
      wd = 32'hAA;
      trigger = 1'b1;
      rd_addr = {5'd5, 5'd5};
      #1;
      checks++;
      if (rd_data !== {2{exp_rd(5'd5)}} || exp_rd(5'd5) !== 32'd1) begin
         errors++;
         $display("FAIL trig_prio_same: got %h, required %h", rd_data, {2{32'd1}});
      end
      tick();
      idle();
      #1;
      checks++;
      if (rd_data !== {2{32'd1}}) begin
         errors++;
         $display("FAIL trig_prio_after: got %h, required %h", rd_data, {2{32'd1}});
      end
   endtask

   task automatic test_random();
      logic [4:0] a0_sel;
      logic [4:0] a1_sel;
      for (int c = 0; c < 400; c++) begin
         we = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0: wa = 5'd10;
            1: wa = 5'd1;
            2: wa = 5'd5;
            3: wa = 5'd0;
            default: wa = 5'($urandom);
         endcase
         wd = $urandom;
         trigger = ($urandom_range(0, 7) == 0);
         a0_sel = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
         a1_sel = ($urandom_range(0, 3) == 0) ? 5'd5 : 5'($urandom);
         rd_addr = {a1_sel, a0_sel};
         #1;
         checks++;
         if (rd_data !== {exp_rd(a1_sel), exp_rd(a0_sel)}) begin
            errors++;
            $display("FAIL random_read: cyc %0d addr %0d/%0d got %h, required %h", c, a0_sel,
                     a1_sel, rd_data, {exp_rd(a1_sel), exp_rd(a0_sel)});
         end
         checks++;
         if (a0 !== exp_tap(10) || ra !== exp_tap(1)) begin
            errors++;
            $display("FAIL random_taps: cyc %0d a0=%h ra=%h, required a0=%h ra=%h", c, a0, ra,
                     exp_tap(10), exp_tap(1));
         end
         tick();
      end
      idle();
   endtask

   task automatic test_trigger_sweep();
      int n;
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 10; c++) tick();
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         tick();
      end
      checks++;
      if (n != 21) begin
         errors++;
         $display("FAIL trig_sweep_len: remaining busy=%0d, required 21", n);
      end
      rd_addr = {5'd6, 5'd5};
      #1;
      checks++;
      if (rd_data !== {exp_rd(5'd6), exp_rd(5'd5)} || exp_rd(5'd5) !== 32'd1) begin
         errors++;
         $display("FAIL trig_sweep_first: got %h, required %h", rd_data, {32'd0, 32'd1});
      end
      tick();
      for (int a = 0; a < 32; a++) begin
         rd_addr = {5'(a), 5'(a)};
         #1;
         checks++;
         if (rd_data !== {2{exp_rd(5'(a))}} || exp_rd(5'(a)) !== ((a == 5) ? 32'd1 : 32'd0))
         begin
            errors++;
            $display("FAIL trig_sweep_entry: addr %0d got %h, required %h", a, rd_data[31:0],
                     (a == 5) ? 32'd1 : 32'd0);
         end
      end
      // Pending flag must be gone: a plain write to x5 now sticks.
      we = 1'b1;
      wa = 5'd5;
      wd = 32'h77;
      tick();
      idle();
      rd_addr = {5'd5, 5'd5};
      #1;
      checks++;
      if (rd_data[31:0] !== 32'h77) begin
         errors++;
         $display("FAIL trig_pend_clear: got %h, required %h", rd_data[31:0], 32'h77);
      end
   endtask

   task automatic test_reset_mid_sweep();
      int n;
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 20; c++) tick();
      rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_busy: busy=%b, required 1", busy);
      end
      tick();
      rst = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         tick();
      end
      checks++;
      if (n != 32) begin
         errors++;
         $display("FAIL mid_reset_len: busy cycles=%0d, required 32", n);
      end
      we = 1'b1;
      wa = 5'd10;
      wd = 32'h55;
      #1;
      checks++;
      if (a0 !== 32'd0) begin
         errors++;
         $display("FAIL tap_no_bypass: a0=%h, required 0", a0);
      end
      tick();
      wa = 5'd1;
      wd = 32'hCAFE0001;
      #1;
      checks++;
      if (a0 !== 32'h55 || ra !== 32'd0) begin
         errors++;
         $display("FAIL tap_a0: a0=%h ra=%h, required a0=55 ra=0", a0, ra);
      end
      tick();
      idle();
      #1;
      checks++;
      if (ra !== 32'hCAFE0001 || a0 !== 32'h55) begin
         errors++;
         $display("FAIL tap_ra: a0=%h ra=%h, required a0=55 ra=cafe0001", a0, ra);
      end
   endtask

   initial begin
      rst = 1'b1;
      rd_addr = '0;
      idle();
      test_reset();
      test_bypass();
      test_x0();
      test_trigger_priority();
      test_random();
      test_trigger_sweep();
      test_random();
      test_reset_mid_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
